// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared state enum and bit-plane index width for the DA datapath
package da_pkg;
    localparam int T_W = 8;

    typedef enum logic {
        DA_IDLE   = 1'b0,
        DA_STREAM = 1'b1
    } da_state_e;
endpackage

// File: rtl/da_plane_fold.sv
// rtl/da_plane_fold.sv - folds one bit-plane into the element-0 bit and XNOR address
module da_plane_fold #(
    parameter int K = 4
) (
    input  logic [K-1:0] plane_i,
    output logic         a0_o,
    output logic [K-2:0] addr_o
);
    assign a0_o   = plane_i[0];
    assign addr_o = ~(plane_i[K-1:1] ^ {(K-1){plane_i[0]}});
endmodule

// File: rtl/da_addr_gen.sv
// rtl/da_addr_gen.sv - streams LSB-first bit-plane addresses of an activation vector
module da_addr_gen
    import da_pkg::*;
#(
    parameter int DATA_WIDTH_A = 8,
    parameter int K            = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH_A-1:0] A [K],
    input  logic                           flush,
    output logic                           gen_done,
    input  logic                           out_ready,
    output logic                           A0,
    output logic [K-2:0]                   addr_array,
    output logic [T_W-1:0]                 t,
    output logic                           last_bit
);
    localparam logic [T_W-1:0] T_LAST = T_W'(DATA_WIDTH_A - 1);

    da_state_e               state_q;
    logic [T_W-1:0]          t_q;
    logic [DATA_WIDTH_A-1:0] sr_q [K];
    logic [K-1:0]            plane;
    logic                    fold_a0;
    logic [K-2:0]            fold_addr;
    logic                    is_last;
    logic                    accept;
    logic                    advance;

    assign gen_done = (state_q == DA_STREAM);
    assign is_last  = gen_done && (t_q == T_LAST);
    assign in_ready = !rst && !flush && (!gen_done || (is_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign advance  = gen_done && out_ready;

    // Bit 0 of each shift-register lane is always the plane currently on the outputs.
    always_comb begin
        plane = '0;
        for (int i = 0; i < K; i++) begin
            plane[i] = sr_q[i][0];
        end
    end

    da_plane_fold #(.K(K)) u_fold (
        .plane_i (plane),
        .a0_o    (fold_a0),
        .addr_o  (fold_addr)
    );

    assign A0         = gen_done & fold_a0;
    assign addr_array = gen_done ? fold_addr : '0;
    assign t          = t_q;
    assign last_bit   = is_last;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= DA_IDLE;
            t_q     <= '0;
            for (int i = 0; i < K; i++) sr_q[i] <= '0;
        end else if (accept) begin
            state_q <= DA_STREAM;
            t_q     <= '0;
            for (int i = 0; i < K; i++) sr_q[i] <= A[i];
        end else if (advance) begin
            if (is_last) begin
                state_q <= DA_IDLE;
                t_q     <= '0;
                for (int i = 0; i < K; i++) sr_q[i] <= '0;
            end else begin
                t_q <= t_q + 1'b1;
                for (int i = 0; i < K; i++) sr_q[i] <= sr_q[i] >> 1;
            end
        end
    end
endmodule

// File: tb/tb_da_addr_gen.sv
// tb/tb_da_addr_gen.sv - self-checking bench for da_addr_gen
module tb_da_addr_gen;
    localparam int W = 8;
    localparam int K = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, in_valid, in_ready, flush, gen_done, out_ready, A0, last_bit;
    logic signed [W-1:0] A [K];
    logic [K-2:0]        addr_array;
    logic [7:0]          t;

    int checks = 0, errors = 0;
    int beats = 0, gd_cnt = 0, hs_mid = 0;
    int b0, g0, h0;

    bit m_busy = 1'b0;
    int m_j = 0;
    int m_vec [K];

    da_addr_gen #(.DATA_WIDTH_A(W), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .flush      (flush),
        .gen_done   (gen_done),
        .out_ready  (out_ready),
        .A0         (A0),
        .addr_array (addr_array),
        .t          (t),
        .last_bit   (last_bit)
    );

    function automatic int bit_of(int v, int j);
        return (v >>> j) & 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the plane/XNOR definition of the current model vector.
    task automatic compare();
        int e_a0, e_addr, e_rdy;
        e_a0   = m_busy ? bit_of(m_vec[0], m_j) : 0;
        e_addr = 0;
        if (m_busy)
            for (int i = 1; i < K; i++)
                if (bit_of(m_vec[i], m_j) == bit_of(m_vec[0], m_j)) e_addr += (1 << (i - 1));
        e_rdy = (!rst && !flush && (!m_busy || (m_j == W - 1 && out_ready))) ? 1 : 0;
        chk("gen_done", int'(gen_done), int'(m_busy));
        chk("in_ready", int'(in_ready), e_rdy);
        chk("t", int'(t), m_busy ? m_j : 0);
        chk("A0", int'(A0), e_a0);
        chk("addr_array", int'(addr_array), e_addr);
        chk("last_bit", int'(last_bit), (m_busy && m_j == W - 1) ? 1 : 0);
        if (gen_done && out_ready) beats++;
        if (gen_done) gd_cnt++;
        if (gen_done && in_ready && in_valid) hs_mid++;
    endtask

    task automatic model_update();
        bit rdy;
        if (rst || flush) begin
            m_busy = 1'b0;
            m_j    = 0;
        end else begin
            rdy = !m_busy || (m_j == W - 1 && out_ready);
            if (in_valid && rdy) begin
                m_busy = 1'b1;
                m_j    = 0;
                for (int i = 0; i < K; i++) m_vec[i] = int'(A[i]);
            end else if (m_busy && out_ready) begin
                if (m_j == W - 1) begin
                    m_busy = 1'b0;
                    m_j    = 0;
                end else begin
                    m_j++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_vec(int a0, int a1, int a2, int a3);
        A[0] = 8'(a0);
        A[1] = 8'(a1);
        A[2] = 8'(a2);
        A[3] = 8'(a3);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_vec(0, 0, 0, 0);
        step(); step();
        chk("rst_gen_done", int'(gen_done), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_addr", int'(addr_array), 0);
        rst = 1'b0; #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        // {3,-1,5,-128}
        set_vec(3, -1, 5, -128); in_valid = 1'b1;
        step();
        in_valid = 1'b0; b0 = beats;
        chk("v1_t0_A0", int'(A0), 1);
        chk("v1_t0_addr", int'(addr_array), 3);
        chk("v1_t0_t", int'(t), 0);
        repeat (7) step();
        chk("v1_t7_t", int'(t), 7);
        chk("v1_t7_A0", int'(A0), 0);
        chk("v1_t7_addr", int'(addr_array), 2);
        chk("v1_t7_last", int'(last_bit), 1);
        step();
        chk("v1_beats", beats - b0, 8);
        chk("v1_idle", int'(gen_done), 0);

        // back-to-back vectors
        g0 = gd_cnt; h0 = hs_mid;
        set_vec(1, 2, 3, 4); in_valid = 1'b1;
        step();
        set_vec(-5, 6, -7, 8);
        repeat (7) step();
        chk("b2b_t7", int'(t), 7);
        step();
        chk("b2b_wrap_t", int'(t), 0);
        chk("b2b_wrap_gd", int'(gen_done), 1);
        in_valid = 1'b0;
        repeat (8) step();
        chk("b2b_gd_cycles", gd_cnt - g0, 16);
        chk("b2b_handshakes", hs_mid - h0, 1);

        // stall at t=4
        set_vec(7, -3, 100, -50); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("stall_enter_t", int'(t), 4);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_t", int'(t), 4);
            chk("stall_gd", int'(gen_done), 1);
        end
        out_ready = 1'b1;
        step();
        chk("stall_resume_t", int'(t), 5);
        repeat (3) step();
        chk("stall_idle", int'(gen_done), 0);

        // flush at t=2 with a waiting vector
        set_vec(-2, 9, -9, 2); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("flush_at_t", int'(t), 2);
        flush = 1'b1; in_valid = 1'b1; set_vec(11, -12, 13, -14); #1;
        chk("flush_in_ready", int'(in_ready), 0);
        step();
        flush = 1'b0; #1;
        chk("flush_gd", int'(gen_done), 0);
        chk("flush_t", int'(t), 0);
        chk("flush_idle_ready", int'(in_ready), 1);
        step();
        chk("post_flush_gd", int'(gen_done), 1);
        chk("post_flush_A0", int'(A0), 1);
        chk("post_flush_addr", int'(addr_array), 2);
        in_valid = 1'b0;
        repeat (8) step();
        chk("post_flush_idle", int'(gen_done), 0);

        // reset at t=5
        set_vec(1, 1, 1, 1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("mid_rst_t", int'(t), 5);
        rst = 1'b1;
        step();
        chk("mid_rst_gd", int'(gen_done), 0);
        chk("mid_rst_A0", int'(A0), 0);
        chk("mid_rst_addr", int'(addr_array), 0);
        chk("mid_rst_t0", int'(t), 0);
        chk("mid_rst_last", int'(last_bit), 0);
        chk("mid_rst_ready", int'(in_ready), 0);
        b0 = beats;
        rst = 1'b0; #1;
        chk("rst_fall_ready", int'(in_ready), 1);
        repeat (3) step();
        chk("no_residual_beats", beats - b0, 0);

        // all-zero and all-ones vectors
        set_vec(0, 0, 0, 0); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < W; b++) begin
            chk("zero_A0", int'(A0), 0);
            chk("zero_addr", int'(addr_array), 7);
            step();
        end
        set_vec(-1, -1, -1, -1); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < W; b++) begin
            chk("ones_A0", int'(A0), 1);
            chk("ones_addr", int'(addr_array), 7);
            step();
        end
        chk("final_idle", int'(gen_done), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
